// File: rtl/data_memory_be.sv
// data_memory_be: byte-enabled synchronous data memory with post-reset clear and 1/2-cycle read latency
module data_memory_be #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic [DATA_WIDTH-1:0]   write_data_i,
    input  logic [ADDR_WIDTH-1:0]   address_i,
    input  logic [DATA_WIDTH/8-1:0] byte_enable_i,
    input  logic                    mem_read_i,
    input  logic                    mem_write_i,
    output logic [DATA_WIDTH-1:0]   read_data_o,
    output logic                    read_valid_o,
    output logic                    ready_o
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_RUN   = 1'b1;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("data_memory_be: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("data_memory_be: DATA_WIDTH must be a multiple of 8");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  state_q, state_d;
    logic                  ready_q, ready_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  p_valid_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  rd_acc, wr_acc, s_valid;
    logic [DATA_WIDTH-1:0] merged, s_data;

    // Merged word serves both the write and a same-cycle read (write-first)
    always_comb begin
        rd_acc = ready_q & mem_read_i;
        wr_acc = ready_q & mem_write_i;
        merged = mem_q[address_i];
        for (int i = 0; i < LANES; i++)
            merged[8*i +: 8] = (wr_acc && byte_enable_i[i]) ? write_data_i[8*i +: 8] : merged[8*i +: 8];
        s_valid = (READ_LATENCY == 2) ? p_valid_q : rd_acc;
        s_data  = (READ_LATENCY == 2) ? p_data_q : merged;
    end

    // Clear sweeps every word once, then the block runs until reset
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (&cnt_q) ? ST_RUN : ST_CLEAR;
        end
        ready_d = (state_d == ST_RUN);
    end

    // Control, read pipeline and output registers
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            ready_q   <= 1'b0;
            cnt_q     <= '0;
            p_valid_q <= 1'b0;
            p_data_q  <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            cnt_q     <= cnt_d;
            p_valid_q <= rd_acc;
            if (rd_acc) p_data_q <= merged;
            valid_q   <= s_valid;
            if (s_valid) data_q <= s_data;
        end
    end

    // Storage: clear writes zero, otherwise accepted writes store the merged word
    always_ff @(posedge clock_i) begin
        if (state_q == ST_CLEAR) mem_q[cnt_q] <= '0;
        else if (wr_acc) mem_q[address_i] <= merged;
    end

    assign read_data_o  = data_q;
    assign read_valid_o = valid_q;
    assign ready_o      = ready_q;
endmodule
